// File: rtl/bus_fifo_bank.sv
// ---------------------------------------------------------------------------
// bus_fifo_bank
//
// Per-driver FIFO bank between the agent/driver layer and the
// bs_gnrtr_n_rbtr bus. Every channel owns two independent first-word
// fall-through FIFOs:
//   ingress : agent -> bus  (in_push/in_data in, pndng/D_pop out, pop in)
//   egress  : bus -> monitor (push/D_push in, out_valid/out_data out,
//             out_pop in)
// A sticky per-channel ovf flag records any packet lost on either FIFO.
//
// Parameters
//   pckg_sz   packet width in bits
//   drvrs     number of channels
//   deep_fifo entries per FIFO (>= 2, any integer)
//   afull_lvl in_afull threshold on ingress occupancy (1..deep_fifo)
//   drop_mode ingress policy when full: 0 reject new, 1 drop oldest
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_push, in_data    agent write into ingress FIFO i
//   in_full, in_afull   ingress full / almost-full flags
//   pndng, D_pop        ingress non-empty flag and FWFT head
//   pop                 bus consumes ingress head
//   push, D_push        bus write into egress FIFO i
//   out_valid, out_data egress non-empty flag and FWFT head
//   out_pop             monitor consumes egress head
//   ovf, ovf_clr        sticky packet-lost flag and its clear
// ---------------------------------------------------------------------------
module bus_fifo_bank #(
  parameter int pckg_sz   = 16,
  parameter int drvrs     = 4,
  parameter int deep_fifo = 8,
  parameter int afull_lvl = 6,
  parameter int drop_mode = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           in_push,
  input  logic [drvrs*pckg_sz-1:0]   in_data,
  output logic [drvrs-1:0]           in_full,
  output logic [drvrs-1:0]           in_afull,
  output logic [drvrs-1:0]           pndng,
  output logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           push,
  input  logic [drvrs*pckg_sz-1:0]   D_push,
  output logic [drvrs-1:0]           out_valid,
  output logic [drvrs*pckg_sz-1:0]   out_data,
  input  logic [drvrs-1:0]           out_pop,
  output logic [drvrs-1:0]           ovf,
  input  logic [drvrs-1:0]           ovf_clr
);

  localparam int CW = $clog2(deep_fifo + 1);
  localparam int PW = (deep_fifo > 1) ? $clog2(deep_fifo) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(deep_fifo);
  localparam logic [CW-1:0] AFULL_CNT = CW'(afull_lvl);
  localparam logic [PW-1:0] LAST_PTR  = PW'(deep_fifo - 1);

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Occupancy update: a write without a read grows, a read without a
  // write shrinks; drop-oldest counts as both and leaves it unchanged.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic wr, input logic rd);
    if (wr && !rd)      return c + CW'(1);
    else if (!wr && rd) return c - CW'(1);
    else                return c;
  endfunction

  for (genvar g = 0; g < drvrs; g++) begin : g_ch
    logic [pckg_sz-1:0] r_in_mem  [deep_fifo];
    logic [pckg_sz-1:0] r_out_mem [deep_fifo];

    logic [PW-1:0] r_in_rd, r_in_wr, r_out_rd, r_out_wr;
    logic [CW-1:0] r_in_cnt, r_out_cnt;
    logic          r_in_full, r_in_afull, r_pndng;
    logic          r_out_full, r_out_valid;
    logic          r_ovf;

    logic          w_in_rd_en, w_in_wr_en, w_in_drop, w_in_adv_rd, w_in_lost;
    logic          w_out_rd_en, w_out_wr_en, w_out_lost;
    logic [CW-1:0] w_in_cnt_nxt, w_out_cnt_nxt;

    always_comb begin
      w_in_rd_en  = pop[g] && r_pndng;
      w_in_wr_en  = 1'b0;
      w_in_drop   = 1'b0;
      w_in_lost   = 1'b0;
      if (in_push[g]) begin
        // A same-cycle pop frees the slot, so a full FIFO still accepts.
        if (!r_in_full || w_in_rd_en) begin
          w_in_wr_en = 1'b1;
        end else if (drop_mode != 0) begin
          w_in_wr_en = 1'b1;
          w_in_drop  = 1'b1;
          w_in_lost  = 1'b1;
        end else begin
          w_in_lost  = 1'b1;
        end
      end
      w_in_adv_rd  = w_in_rd_en || w_in_drop;
      w_in_cnt_nxt = cnt_next(r_in_cnt, w_in_wr_en, w_in_adv_rd);

      w_out_rd_en   = out_pop[g] && r_out_valid;
      w_out_wr_en   = push[g] && (!r_out_full || w_out_rd_en);
      w_out_lost    = push[g] && r_out_full && !w_out_rd_en;
      w_out_cnt_nxt = cnt_next(r_out_cnt, w_out_wr_en, w_out_rd_en);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_in_rd     <= '0;
        r_in_wr     <= '0;
        r_in_cnt    <= '0;
        r_in_full   <= 1'b0;
        r_in_afull  <= 1'b0;
        r_pndng     <= 1'b0;
        r_out_rd    <= '0;
        r_out_wr    <= '0;
        r_out_cnt   <= '0;
        r_out_full  <= 1'b0;
        r_out_valid <= 1'b0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_in_adv_rd) r_in_rd <= ptr_inc(r_in_rd);
        if (w_in_wr_en)  r_in_wr <= ptr_inc(r_in_wr);
        r_in_cnt    <= w_in_cnt_nxt;
        r_in_full   <= (w_in_cnt_nxt == FULL_CNT);
        r_in_afull  <= (w_in_cnt_nxt >= AFULL_CNT);
        r_pndng     <= (w_in_cnt_nxt != '0);

        if (w_out_rd_en) r_out_rd <= ptr_inc(r_out_rd);
        if (w_out_wr_en) r_out_wr <= ptr_inc(r_out_wr);
        r_out_cnt   <= w_out_cnt_nxt;
        r_out_full  <= (w_out_cnt_nxt == FULL_CNT);
        r_out_valid <= (w_out_cnt_nxt != '0);

        // Set has priority over a same-cycle clear.
        r_ovf <= w_in_lost || w_out_lost || (r_ovf && !ovf_clr[g]);
      end
    end

    // Storage has no reset; its contents are only observed through the
    // gated heads below.
    always_ff @(posedge clk) begin
      if (w_in_wr_en)  r_in_mem[r_in_wr]   <= in_data[g*pckg_sz +: pckg_sz];
      if (w_out_wr_en) r_out_mem[r_out_wr] <= D_push[g*pckg_sz +: pckg_sz];
    end

    // Heads read storage at the registered read pointer and are forced to
    // zero while the FIFO is empty, which also covers the reset state.
    assign D_pop[g*pckg_sz +: pckg_sz]    = r_pndng     ? r_in_mem[r_in_rd]   : '0;
    assign out_data[g*pckg_sz +: pckg_sz] = r_out_valid ? r_out_mem[r_out_rd] : '0;

    assign in_full[g]   = r_in_full;
    assign in_afull[g]  = r_in_afull;
    assign pndng[g]     = r_pndng;
    assign out_valid[g] = r_out_valid;
    assign ovf[g]       = r_ovf;
  end

endmodule

// File: tb/tb_bus_fifo_bank.sv
// ---------------------------------------------------------------------------
// tb_bus_fifo_bank
//
// Two instances of bus_fifo_bank share one stimulus: inst 0 rejects new
// packets when full, inst 1 drops the oldest. A queue-based model of each
// channel predicts every output; a compare process checks all outputs at
// every falling edge, and directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_bus_fifo_bank;
  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 8;
  localparam int AF = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_push, pop, push, out_pop, ovf_clr;
  logic [N*W-1:0] in_data, D_push;

  logic [N-1:0]   full_o  [2];
  logic [N-1:0]   afull_o [2];
  logic [N-1:0]   pndng_o [2];
  logic [N-1:0]   oval_o  [2];
  logic [N-1:0]   ovf_o   [2];
  logic [N*W-1:0] dpop_o  [2];
  logic [N*W-1:0] odat_o  [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_fifo_bank #(.pckg_sz(W), .drvrs(N), .deep_fifo(D), .afull_lvl(AF),
                  .drop_mode(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_push(in_push), .in_data(in_data),
    .in_full(full_o[0]), .in_afull(afull_o[0]), .pndng(pndng_o[0]),
    .D_pop(dpop_o[0]), .pop(pop),
    .push(push), .D_push(D_push),
    .out_valid(oval_o[0]), .out_data(odat_o[0]), .out_pop(out_pop),
    .ovf(ovf_o[0]), .ovf_clr(ovf_clr));

  bus_fifo_bank #(.pckg_sz(W), .drvrs(N), .deep_fifo(D), .afull_lvl(AF),
                  .drop_mode(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_push(in_push), .in_data(in_data),
    .in_full(full_o[1]), .in_afull(afull_o[1]), .pndng(pndng_o[1]),
    .D_pop(dpop_o[1]), .pop(pop),
    .push(push), .D_push(D_push),
    .out_valid(oval_o[1]), .out_data(odat_o[1]), .out_pop(out_pop),
    .ovf(ovf_o[1]), .ovf_clr(ovf_clr));

  task automatic chk(input string nm, input int id,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] actual=%h required=%h t=%0t", nm, id, act, exp, $time);
  endtask

  // ---------------- behavioural model: plain queues per channel -----------
  logic [W-1:0] mq_in  [2*N][$];
  logic [W-1:0] mq_out [2*N][$];
  logic [N-1:0] m_ovf  [2];

  task automatic model_step(input int m, input int c);
    int k;
    bit lost;
    logic [W-1:0] dv;
    k = m*N + c;
    lost = 1'b0;
    if (pop[c] && mq_in[k].size() != 0) void'(mq_in[k].pop_front());
    if (in_push[c]) begin
      dv = in_data[c*W +: W];
      if (mq_in[k].size() < D) mq_in[k].push_back(dv);
      else begin
        lost = 1'b1;
        if (m == 1) begin
          void'(mq_in[k].pop_front());
          mq_in[k].push_back(dv);
        end
      end
    end
    if (out_pop[c] && mq_out[k].size() != 0) void'(mq_out[k].pop_front());
    if (push[c]) begin
      if (mq_out[k].size() < D) mq_out[k].push_back(D_push[c*W +: W]);
      else lost = 1'b1;
    end
    m_ovf[m][c] = lost | (m_ovf[m][c] & ~ovf_clr[c]);
  endtask

  initial begin
    m_ovf[0] = '0;
    m_ovf[1] = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int k = 0; k < 2*N; k++) begin
          mq_in[k].delete();
          mq_out[k].delete();
        end
        m_ovf[0] = '0;
        m_ovf[1] = '0;
      end else begin
        for (int m = 0; m < 2; m++)
          for (int c = 0; c < N; c++) model_step(m, c);
      end
    end
  end

  // ---------------- per-cycle compare against the model ------------------
  logic [N-1:0]   e_full, e_afull, e_pndng, e_oval;
  logic [N*W-1:0] e_dpop, e_odat, mk_d, mk_o;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int m = 0; m < 2; m++) begin
          for (int c = 0; c < N; c++) begin
            int k;
            k = m*N + c;
            e_pndng[c] = (mq_in[k].size() != 0);
            e_full[c]  = (mq_in[k].size() == D);
            e_afull[c] = (mq_in[k].size() >= AF);
            e_oval[c]  = (mq_out[k].size() != 0);
            e_dpop[c*W +: W] = e_pndng[c] ? mq_in[k][0]  : '0;
            e_odat[c*W +: W] = e_oval[c]  ? mq_out[k][0] : '0;
            // Heads are only defined while non-empty, or zero during reset.
            mk_d[c*W +: W] = (e_pndng[c] || !reset) ? '1 : '0;
            mk_o[c*W +: W] = (e_oval[c]  || !reset) ? '1 : '0;
          end
          chk("pndng",     m, pndng_o[m], e_pndng);
          chk("in_full",   m, full_o[m],  e_full);
          chk("in_afull",  m, afull_o[m], e_afull);
          chk("out_valid", m, oval_o[m],  e_oval);
          chk("ovf",       m, ovf_o[m],   m_ovf[m]);
          chk("D_pop",     m, dpop_o[m] & mk_d, e_dpop & mk_d);
          chk("out_data",  m, odat_o[m] & mk_o, e_odat & mk_o);
        end
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    in_push = '0; pop = '0; push = '0; out_pop = '0; ovf_clr = '0;
    in_data = '0; D_push = '0;
  endtask

  function automatic logic [W-1:0] head(input int m, input int c);
    return dpop_o[m][c*W +: W];
  endfunction

  logic [W-1:0] exp_v, exp0, exp1;

  initial begin
    zero_in();
    // 1. Reset with random inputs, then first write visibility
    for (int i = 0; i < 3; i++) begin
      in_push = N'($urandom); pop = N'($urandom); push = N'($urandom);
      out_pop = N'($urandom); ovf_clr = N'($urandom);
      in_data = {$urandom, $urandom}; D_push = {$urandom, $urandom};
      cyc();
      chk_en = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      chk("rst_pndng", m, pndng_o[m], 0);
      chk("rst_oval",  m, oval_o[m], 0);
      chk("rst_ovf",   m, ovf_o[m], 0);
      chk("rst_dpop",  m, dpop_o[m], 0);
    end
    zero_in();
    reset = 1'b1;
    cyc();
    in_push[1] = 1'b1; in_data[1*W +: W] = 16'h0203;
    cyc();
    zero_in();
    for (int m = 0; m < 2; m++) begin
      chk("t1_pndng", m, pndng_o[m], 4'b0010);
      chk("t1_dpop1", m, head(m, 1), 16'h0203);
    end
    pop[1] = 1'b1;
    cyc();
    zero_in();

    // 2. Order and wrap on ch2, almost-full threshold
    exp_v = 16'h0001;
    for (int v = 1; v <= 6; v++) begin
      in_push[2] = 1'b1; in_data[2*W +: W] = 16'(v);
      cyc();
      if (v == 5) chk("t2_afull5", 0, afull_o[0][2], 0);
      if (v == 6) chk("t2_afull6", 0, afull_o[0][2], 1);
    end
    zero_in();
    chk("t2_head", 0, head(0, 2), exp_v);
    exp_v++;
    pop[2] = 1'b1;
    cyc();
    zero_in();
    chk("t2_afull_clr", 1, afull_o[1][2], 0);
    for (int v = 7; v <= 20; v++) begin
      chk("t2_head", 0, head(0, 2), exp_v);
      chk("t2_head", 1, head(1, 2), exp_v);
      exp_v++;
      in_push[2] = 1'b1; in_data[2*W +: W] = 16'(v); pop[2] = 1'b1;
      cyc();
    end
    zero_in();
    for (int i = 0; i < 5; i++) begin
      chk("t2_head", 0, head(0, 2), exp_v);
      exp_v++;
      pop[2] = 1'b1;
      cyc();
    end
    zero_in();
    chk("t2_empty", 0, pndng_o[0][2], 0);

    // 3/4. Overflow on ch0: reject (inst 0) versus drop-oldest (inst 1)
    for (int i = 0; i < 8; i++) begin
      in_push[0] = 1'b1; in_data[W-1:0] = 16'h0A00 + 16'(i);
      cyc();
    end
    in_data[W-1:0] = 16'h0AFF;
    cyc();
    zero_in();
    for (int m = 0; m < 2; m++) begin
      chk("t3_full", m, full_o[m][0], 1);
      chk("t3_ovf",  m, ovf_o[m][0], 1);
    end
    for (int i = 0; i < 8; i++) begin
      exp0 = 16'h0A00 + 16'(i);
      exp1 = (i < 7) ? 16'h0A01 + 16'(i) : 16'h0AFF;
      chk("t3_drain", 0, head(0, 0), exp0);
      chk("t4_drain", 1, head(1, 0), exp1);
      pop[0] = 1'b1;
      cyc();
    end
    zero_in();
    chk("t3_empty", 0, pndng_o[0][0], 0);
    ovf_clr[0] = 1'b1;
    cyc();
    zero_in();
    chk("t3_ovfclr", 0, ovf_o[0][0], 0);
    chk("t4_ovfclr", 1, ovf_o[1][0], 0);

    // 5. Simultaneous events
    for (int i = 0; i < 8; i++) begin
      in_push[0] = 1'b1; in_data[W-1:0] = 16'h0C00 + 16'(i);
      cyc();
    end
    in_data[W-1:0] = 16'h0CFF; pop[0] = 1'b1;
    cyc();
    zero_in();
    for (int m = 0; m < 2; m++) begin
      chk("t5_full_pp", m, full_o[m][0], 1);
      chk("t5_ovf_pp",  m, ovf_o[m][0], 0);
      chk("t5_head_pp", m, head(m, 0), 16'h0C01);
    end
    in_push[0] = 1'b1; in_data[W-1:0] = 16'h0CEE; ovf_clr[0] = 1'b1;
    cyc();
    zero_in();
    chk("t5_set_wins", 0, ovf_o[0][0], 1);
    chk("t5_set_wins", 1, ovf_o[1][0], 1);
    for (int i = 0; i < 8; i++) begin
      pop[0] = 1'b1;
      cyc();
    end
    zero_in();
    ovf_clr = '1;
    cyc();
    zero_in();
    in_push[0] = 1'b1; in_data[W-1:0] = 16'h0D00; pop[0] = 1'b1;
    cyc();
    zero_in();
    chk("t5_empty_pp", 0, pndng_o[0][0], 1);
    chk("t5_empty_hd", 0, head(0, 0), 16'h0D00);
    chk("t5_empty_nf", 1, full_o[1][0], 0);
    pop[0] = 1'b1;
    cyc();
    zero_in();

    // 6. Egress overflow on ch3
    for (int i = 0; i < 9; i++) begin
      push[3] = 1'b1; D_push[3*W +: W] = 16'h0204;
      cyc();
    end
    zero_in();
    chk("t6_oval", 0, oval_o[0][3], 1);
    chk("t6_ovf",  0, ovf_o[0][3], 1);
    chk("t6_ovf",  1, ovf_o[1][3], 1);
    for (int i = 0; i < 8; i++) begin
      chk("t6_oval_i", 0, oval_o[0][3], 1);
      chk("t6_odat_i", 0, odat_o[0][3*W +: W], 16'h0204);
      out_pop[3] = 1'b1;
      cyc();
    end
    zero_in();
    chk("t6_drained", 0, oval_o[0][3], 0);
    ovf_clr = '1;
    cyc();
    zero_in();

    // Random traffic with varying fill bias and a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      int pw, pr;
      case ((n / 250) % 3)
        0:       begin pw = 80; pr = 20; end
        1:       begin pw = 50; pr = 50; end
        default: begin pw = 20; pr = 80; end
      endcase
      for (int c = 0; c < N; c++) begin
        in_push[c] = ($urandom_range(0, 99) < pw);
        push[c]    = ($urandom_range(0, 99) < pw);
        pop[c]     = ($urandom_range(0, 99) < pr);
        out_pop[c] = ($urandom_range(0, 99) < pr);
        ovf_clr[c] = ($urandom_range(0, 15) == 0);
      end
      in_data = {$urandom, $urandom};
      D_push  = {$urandom, $urandom};
      if (n == 1500) reset = 1'b0;
      if (n == 1503) reset = 1'b1;
      cyc();
    end
    zero_in();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_fifo_bank.md
Name: bus_fifo_bank

Overview:
Parametrised per-driver FIFO bank that sits between the agent/driver layer and the bs_gnrtr_n_rbtr bus. Each of drvrs channels has two FIFOs:
- An ingress FIFO that presents pndng/D_pop to the bus and drains on pop.
- An egress FIFO that captures push/D_push from the bus for the monitor.

This block replaces the behavioural driver-side queues with synthesizable RTL. It adds a configurable depth, an almost-full threshold, a selectable overflow policy and sticky overflow flags.

Parameters:
- pckg_sz, 16, packet width in bits
- drvrs, 4, number of channels/bus terminals
- deep_fifo, 8, entries per FIFO (>=2, any integer; not restricted to a power of two)
- afull_lvl, 6, in_afull asserts when ingress occupancy >= afull_lvl (1..deep_fifo)
- drop_mode, 0, ingress policy when full: 0 = reject new packet, 1 = drop oldest packet

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- in_push  in  drvrs  agent writes in_data[i] into ingress FIFO i
- in_data  in  drvrs*pckg_sz  channel i at bits [i*pckg_sz +: pckg_sz]
- in_full  out  drvrs  ingress FIFO i holds deep_fifo entries
- in_afull  out  drvrs  ingress occupancy >= afull_lvl
- pndng  out  drvrs  ingress FIFO i non-empty
- D_pop  out  drvrs*pckg_sz  head of ingress FIFO i (first-word fall-through)
- pop  in  drvrs  bus consumes head of ingress FIFO i
- push  in  drvrs  bus delivers D_push[i] to egress FIFO i
- D_push  in  drvrs*pckg_sz  bus data per channel
- out_valid  out  drvrs  egress FIFO i non-empty
- out_data  out  drvrs*pckg_sz  head of egress FIFO i (FWFT)
- out_pop  in  drvrs  monitor consumes egress head i
- ovf  out  drvrs  sticky: a packet was lost on channel i
- ovf_clr  in  drvrs  clears ovf[i]

Behaviour:
- Reset (reset=0, asynchronous):
  - All occupancy counters, read pointers and write pointers go to 0.
  - pndng, out_valid, in_full, in_afull and ovf go to 0.
  - D_pop and out_data go to 0.
  - Storage contents are don't-care.
  - A reset asserted mid-transfer discards all queued packets. The first clk edge after release is a normal cycle.
- Channels are fully independent. There is no cross-channel arbitration in this block.
- FWFT:
  - D_pop[i] is valid whenever pndng[i]=1.
  - A packet written at edge N appears on pndng/D_pop after edge N, giving 1-cycle write-to-visible latency.
  - Egress behaves identically using out_valid/out_data.
- Pointers wrap from deep_fifo-1 to 0.
- Occupancy counter width is $clog2(deep_fifo+1).
- Flags are registered, derived from next-state occupancy:
  - in_full = (count == deep_fifo)
  - pndng = (count != 0)
- Reads when empty:
  - pop[i] while pndng[i]=0 is ignored, with no pointer or count change.
  - out_pop behaves the same with out_valid.
- Ingress push and pop in the same cycle:
  - Non-empty: both take effect and the count is unchanged.
  - Empty: only the push takes effect.
- Ingress full, in_push=1, pop=1: the push is accepted, the count stays deep_fifo, and ovf is not set (in both modes).
- Ingress full, in_push=1, pop=0:
  - drop_mode=0: the new packet is discarded, storage is unchanged, and ovf[i] is set.
  - drop_mode=1: the read pointer advances, the new packet is written at the write pointer, the count stays deep_fifo, D_pop shows the next-oldest packet, and ovf[i] is set.
- Egress FIFO always rejects on full. push while full with out_pop=0 discards D_push and sets ovf[i]. push and out_pop together while full is accepted.
- ovf[i] is sticky until ovf_clr[i]. If a set event and ovf_clr occur in the same cycle, the set wins and ovf stays 1.
- No combinational path from any input to any output. All outputs are registered or come from storage read at a registered pointer.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0. Release, then in_push[1] with 16'h0203 -> pndng[1]=1 and D_pop[1]=16'h0203 one cycle later; other channels stay idle.
2. Order/wrap: 20 pushes 16'h0001..16'h0014 on ch2, interleaved with pops, never full -> D_pop sequence matches exactly; pointers wrap twice; afull asserts at count 6 and clears at 5.
3. Full, reject (drop_mode=0): 8 pushes 16'h0A00..16'h0A07 on ch0, then push 16'h0AFF -> in_full=1, ovf[0]=1; drained sequence is 16'h0A00..16'h0A07 with no 16'h0AFF. ovf_clr[0] -> ovf[0]=0.
4. Full, drop-oldest (drop_mode=1): same stimulus as 3 -> ovf[0]=1; drained sequence is 16'h0A01..16'h0A07, 16'h0AFF.
5. Simultaneous events: at full, push and pop together -> count stays 8, ovf=0. At empty, push and pop together -> count becomes 1, no underflow. ovf_clr in the same cycle as an overflow -> ovf stays 1.
6. Egress: bus push of 16'h0204 on ch3 nine times without out_pop -> out_valid[3]=1, 8 entries retained, ovf[3]=1. Popping returns 8 values in order.
